// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame: start(0), width data bits LSB first, optional parity, one stop(1).
// Prescale (8/16/32, anything else means 8) and the parity setup are latched
// when the start bit is detected. The edge counter starts at 0 in the first
// START cycle; each bit is resolved at edge count Prescale/2 and acted on at
// edge count Prescale-1, so both sampling modes have the same latency.
// Optional build macro: UART_RX_MAJORITY_SAMPLE_EN selects 2-of-3 majority
// sampling at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1.
module uart_rx #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             RX_IN,
    input  logic [5:0]       Prescale,
    input  logic             Parity_EN,
    input  logic             Parity_type,
    output logic [width-1:0] P_DATA,
    output logic             Data_valid,
    output logic             Parity_error,
    output logic             Stop_error,
    output logic             Busy
);

    localparam int BW = (width > 1) ? $clog2(width) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_next;
    logic [5:0]       presc_q, presc_sel, edge_cnt, half;
    logic [BW-1:0]    bit_cnt;
    logic             par_en_q, par_type_q;
    logic             armed, bit_val, par_bit;
    logic [width-1:0] shreg;
    logic             start_det, last_edge, last_bit, exp_par, parity_bad;

    assign start_det = (state == IDLE) && armed && !RX_IN;
    assign last_edge = (edge_cnt == presc_q - 6'd1);
    assign last_bit  = (bit_cnt == BW'(width - 1));
    assign half      = presc_q >> 1;
    assign exp_par    = par_type_q ? ~^shreg : ^shreg;
    assign parity_bad = par_en_q && (par_bit != exp_par);
    assign Busy       = (state != IDLE);

    // Map the oversampling ratio onto the legal set
    always_comb begin
        presc_sel = 6'd8;
        case (Prescale)
            6'd8, 6'd16, 6'd32: presc_sel = Prescale;
            default:            presc_sel = 6'd8;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; transitions only at bit boundaries after leaving IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_det) state_next = START;
            START:   if (last_edge) state_next = bit_val ? IDLE : DATA;
            DATA:    if (last_edge && last_bit) state_next = par_en_q ? PARITY : STOP;
            PARITY:  if (last_edge) state_next = STOP;
            STOP:    if (last_edge) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Edge/bit counters and frame configuration latched at start detection
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            presc_q    <= 6'd8;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
        end else if (start_det) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            presc_q    <= presc_sel;
            par_en_q   <= Parity_EN;
            par_type_q <= Parity_type;
        end else if (state != IDLE) begin
            edge_cnt <= last_edge ? 6'd0 : edge_cnt + 6'd1;
            if (state == DATA && last_edge)
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end else begin
            edge_cnt <= '0;
        end
    end

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    logic smp0, smp1;

    // Majority vote over three mid-bit samples, resolved at Prescale/2+1
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            smp0    <= 1'b0;
            smp1    <= 1'b0;
            bit_val <= 1'b0;
        end else if (state != IDLE) begin
            if (edge_cnt == half - 6'd1) smp0 <= RX_IN;
            if (edge_cnt == half)        smp1 <= RX_IN;
            if (edge_cnt == half + 6'd1)
                bit_val <= (smp0 & smp1) | (smp0 & RX_IN) | (smp1 & RX_IN);
        end
    end
`else
    // Single mid-bit sample at Prescale/2
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)                                  bit_val <= 1'b0;
        else if (state != IDLE && edge_cnt == half) bit_val <= RX_IN;
    end
`endif

    // Armed flag, data shift register and received parity bit
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            armed   <= 1'b0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (RX_IN) armed <= 1'b1;
            if (state == DATA && last_edge)   shreg   <= {bit_val, shreg[width-1:1]};
            if (state == PARITY && last_edge) par_bit <= bit_val;
        end
    end

    // Frame-end result: load data and pulse valid, or pulse the error flags
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            P_DATA       <= '0;
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            Stop_error   <= 1'b0;
        end else begin
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            Stop_error   <= 1'b0;
            if (state == STOP && last_edge) begin
                Parity_error <= parity_bad;
                Stop_error   <= !bit_val;
                if (!parity_bad && bit_val) begin
                    P_DATA     <= shreg;
                    Data_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter SHALL be: width, 8, number of data bits per frame.
REQ-002 Port SHALL be: CLK  input  1  single clock; all sequential logic on rising edge.
REQ-003 Port SHALL be: Reset  input  1  asynchronous, active-high reset; port named Reset, clock named CLK.
REQ-004 Port SHALL be: RX_IN  input  1  serial line, idle high, already synchronised to CLK.
REQ-005 Port SHALL be: Prescale  input  6  oversampling ratio, legal values 8/16/32.
REQ-006 Port SHALL be: Parity_EN  input  1  1 = frame carries a parity bit after the data bits.
REQ-007 Port SHALL be: Parity_type  input  1  1 = odd (parity = ~^data), 0 = even (parity = ^data).
REQ-008 Port SHALL be: P_DATA  output  width  last good received word.
REQ-009 Port SHALL be: Data_valid  output  1  one-cycle pulse when P_DATA updates.
REQ-010 Port SHALL be: Parity_error  output  1  one-cycle pulse on parity mismatch.
REQ-011 Port SHALL be: Stop_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-012 Port SHALL be: Busy  output  1  high from start-bit detection until frame end.

Function
REQ-013 Frame SHALL be: start(0), width data bits LSB first, optional parity, one stop(1); each bit lasts Prescale CLK cycles.
REQ-014 Any Prescale value other than 8/16/32 SHALL be treated as 8.
REQ-015 Prescale, Parity_EN and Parity_type SHALL be latched at start detection and held for the whole frame.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 An edge counter SHALL count 0..Prescale-1 within each bit; a bit counter SHALL count data bits 0..width-1.
REQ-018 IDLE->START SHALL occur only on the first cycle RX_IN=0 while the armed flag is set.
REQ-019 The armed flag SHALL clear on reset and set once RX_IN has been sampled high, so a line held low after reset does not start a frame.
REQ-020 Each bit SHALL be sampled at edge count Prescale/2 (single-sample mode, see REQ-031).
REQ-021 A start bit sampled 1 SHALL be a glitch: return to IDLE at the end of the start-bit period with no output pulses.
REQ-022 DATA->PARITY, or DATA->STOP when the latched Parity_EN=0, SHALL occur at the end of bit width-1.
REQ-023 A parity mismatch SHALL pulse Parity_error for one cycle in the cycle after the last STOP edge count.
REQ-024 A stop bit sampled 0 SHALL pulse Stop_error in that same cycle; both errors may pulse together.
REQ-025 When no error occurs, P_DATA SHALL load and Data_valid SHALL pulse one cycle after edge count Prescale-1 of the stop bit; frame latency is (width+2+Parity_EN)*Prescale+1 cycles from the start edge.
REQ-026 On any error, P_DATA SHALL hold its previous value and Data_valid SHALL stay 0.
REQ-027 STOP SHALL return to IDLE; a start edge in that next cycle SHALL begin a new frame, so back-to-back frames are received.
REQ-028 Busy SHALL be high in START/DATA/PARITY/STOP and low in IDLE.

Reset
REQ-029 Asserting Reset at any time, mid-frame included, SHALL force IDLE, clear all counters, the armed flag and the shift register, and drive P_DATA=0, Data_valid=0, Parity_error=0, Stop_error=0, Busy=0.
REQ-030 Reset deassertion SHALL take effect on the next CLK edge; no output pulse SHALL occur due to reset.

Configuration
REQ-031 Macro UART_RX_MAJORITY_SAMPLE_EN: when defined, each bit SHALL be the 2-of-3 majority of samples at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1; when undefined, a single sample at Prescale/2 SHALL be used, with identical latency.

Verification
REQ-032 Prescale=8, parity even, frame 0xA5 with parity 0 and stop 1 -> P_DATA=0xA5, Data_valid pulse 89 cycles after the start edge, no errors.
REQ-033 Same frame but parity bit 1 -> Parity_error pulse, Data_valid=0, P_DATA keeps its prior value.
REQ-034 Prescale=16, Parity_EN=0, 0x3C sent with stop bit 0 -> Stop_error pulse, no Data_valid; the next back-to-back frame 0x81 -> P_DATA=0x81.
REQ-035 Prescale=16, RX_IN low for 3 cycles only -> Busy pulses for one bit period, then IDLE with no outputs; Reset asserted in the middle of a 0xFF frame -> all outputs 0, next frame 0x55 is received correctly.
REQ-036 With the macro defined, RX_IN inverted for the single cycle at edge count Prescale/2 of data bit 3 of 0x00 -> P_DATA=0x00; with the macro undefined -> P_DATA=0x08.
